// File: rtl/outport_credit_alloc.sv
// Per-output round-robin crossbar scheduler with downstream credit tracking
// and wormhole locking of an output to one input for the length of a packet.
module outport_credit_alloc #(
    parameter int P  = 7,
    parameter int B  = 4,
    parameter int CW = $clog2(B + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [P*P-1:0]   req_all,
    input  logic [P-1:0]     tail_all,
    input  logic [P-1:0]     credit_in_all,
    output logic [P*P-1:0]   grant_all,
    output logic [P-1:0]     outport_available_all,
    output logic             credit_ovf_err
);

    localparam int PW = (P > 1) ? $clog2(P) : 1;

    genvar gi, gj;

    // req_san[i][j]: input i requests output j after keeping only the lowest set bit
    logic [P-1:0][P-1:0] req_san;
    // gnt_col[j][i]: output j grants input i
    logic [P-1:0][P-1:0] gnt_col;
    logic [P-1:0]        ovf_hit;

    generate
        for (gi = 0; gi < P; gi++) begin : g_row
            assign req_san[gi] = req_all[gi*P +: P] & (~req_all[gi*P +: P] + P'(1));
        end

        for (gj = 0; gj < P; gj++) begin : g_out
            logic [CW-1:0] credit_cnt_reg;
            logic [CW-1:0] credit_cnt_next;
            logic [PW-1:0] rr_ptr_reg;
            logic          lock_valid_reg;
            logic [PW-1:0] lock_owner_reg;
            logic [P-1:0]  elig;
            logic [P-1:0]  col_gnt;
            logic [PW-1:0] g_idx;
            logic          g_any;

            for (gi = 0; gi < P; gi++) begin : g_elig
                assign elig[gi] = req_san[gi][gj] && (credit_cnt_reg != '0) &&
                                  (!lock_valid_reg || (lock_owner_reg == PW'(gi)));
            end

            // Scan inputs starting at the round-robin pointer, wrapping mod P
            always_comb begin
                logic [PW:0]   sum;
                logic [PW-1:0] idx;
                col_gnt = '0;
                g_idx   = '0;
                g_any   = 1'b0;
                for (int k = 0; k < P; k++) begin
                    sum = {1'b0, rr_ptr_reg} + (PW+1)'(k);
                    if (sum >= (PW+1)'(P)) begin
                        sum = sum - (PW+1)'(P);
                    end
                    idx = sum[PW-1:0];
                    if (!g_any && elig[idx]) begin
                        col_gnt[idx] = 1'b1;
                        g_idx        = idx;
                        g_any        = 1'b1;
                    end
                end
            end

            // A grant only happens with a non-zero count, so only the top end needs clamping
            always_comb begin
                credit_cnt_next = credit_cnt_reg;
                if (credit_in_all[gj] && !g_any) begin
                    if (credit_cnt_reg != CW'(B)) begin
                        credit_cnt_next = credit_cnt_reg + CW'(1);
                    end
                end else if (!credit_in_all[gj] && g_any) begin
                    credit_cnt_next = credit_cnt_reg - CW'(1);
                end
            end

            assign ovf_hit[gj] = credit_in_all[gj] && !g_any && (credit_cnt_reg == CW'(B));
            assign gnt_col[gj] = col_gnt;
            assign outport_available_all[gj] = (credit_cnt_reg != '0);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    credit_cnt_reg <= CW'(B);
                    rr_ptr_reg     <= '0;
                    lock_valid_reg <= 1'b0;
                    lock_owner_reg <= '0;
                end else begin
                    credit_cnt_reg <= credit_cnt_next;
                    if (g_any) begin
                        rr_ptr_reg <= (g_idx == PW'(P - 1)) ? '0 : g_idx + PW'(1);
                        if (tail_all[g_idx]) begin
                            lock_valid_reg <= 1'b0;
                        end else begin
                            lock_valid_reg <= 1'b1;
                            lock_owner_reg <= g_idx;
                        end
                    end
                end
            end

            for (gi = 0; gi < P; gi++) begin : g_gnt
                assign grant_all[gi*P + gj] = gnt_col[gj][gi] & ~rst;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_ovf_err <= 1'b0;
        end else if (|ovf_hit) begin
            credit_ovf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_outport_credit_alloc.sv
// Directed-vector bench for outport_credit_alloc: arbitration order, credits,
// wormhole locking, request sanitising and asynchronous reset.
module tb_outport_credit_alloc;

    localparam int P = 7;
    localparam int B = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [P*P-1:0]   req_all;
    logic [P-1:0]     tail_all;
    logic [P-1:0]     credit_in_all;
    logic [P*P-1:0]   grant_all;
    logic [P-1:0]     outport_available_all;
    logic             credit_ovf_err;

    int n_checks = 0;
    int n_fail   = 0;

    outport_credit_alloc #(.P(P), .B(B)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .req_all               (req_all),
        .tail_all              (tail_all),
        .credit_in_all         (credit_in_all),
        .grant_all             (grant_all),
        .outport_available_all (outport_available_all),
        .credit_ovf_err        (credit_ovf_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    function automatic logic [P*P-1:0] gb(input int i, input int j);
        logic [P*P-1:0] v;
        v = '0;
        v[i*P + j] = 1'b1;
        return v;
    endfunction

    // Called at posedge+1: check combinational grant, then advance one clock
    task automatic cyc(input string tag, input logic [P*P-1:0] exp);
        #1;
        check_eq(tag, grant_all, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_all       = '0;
        tail_all      = '0;
        credit_in_all = '0;
        rst           = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_grant", grant_all, '0);
        rst = 1'b0;
    endtask

    initial begin
        // Test 1: round-robin among inputs 0,2,5 for output 3
        do_reset();
        check_eq("t1_avail_rst", outport_available_all, 7'h7f);
        check_eq("t1_ovf_rst", credit_ovf_err, 1'b0);
        req_all  = gb(0,3) | gb(2,3) | gb(5,3);
        tail_all = 7'h7f;
        cyc("t1_g0", gb(0,3));
        cyc("t1_g2", gb(2,3));
        cyc("t1_g5", gb(5,3));
        req_all = gb(0,3) | gb(6,3);
        cyc("t1_rr6", gb(6,3));
        cyc("t1_nocred", '0);
        check_eq("t1_avail3", outport_available_all[3], 1'b0);

        // Test 2: credit exhaustion and single credit return on output 0
        do_reset();
        req_all  = gb(1,0);
        tail_all = 7'h7f;
        for (int n = 0; n < B; n++) cyc("t2_grant", gb(1,0));
        check_eq("t2_avail0", outport_available_all[0], 1'b0);
        credit_in_all = 7'h01;
        cyc("t2_empty", '0);
        credit_in_all = '0;
        cyc("t2_one_more", gb(1,0));
        cyc("t2_empty2", '0);

        // Test 3: 3-flit packet from input 4 on output 2, contending input 1
        do_reset();
        req_all       = gb(2,2);
        tail_all      = 7'h7f;
        credit_in_all = 7'h04;
        cyc("t3_prime", gb(2,2));
        credit_in_all = '0;
        req_all       = gb(4,2) | gb(1,2);
        tail_all      = '0;
        cyc("t3_head", gb(4,2));
        cyc("t3_body", gb(4,2));
        req_all = gb(1,2);
        cyc("t3_wormhole", '0);
        req_all  = gb(4,2) | gb(1,2);
        tail_all = 7'h10;
        cyc("t3_tail", gb(4,2));
        req_all  = gb(1,2);
        tail_all = 7'h7f;
        cyc("t3_in1", gb(1,2));
        check_eq("t3_avail2", outport_available_all[2], 1'b0);

        // Test 4: simultaneous grant+credit, then saturation and overflow flag
        do_reset();
        req_all  = gb(0,6);
        tail_all = 7'h7f;
        cyc("t4_g1", gb(0,6));
        cyc("t4_g2", gb(0,6));
        credit_in_all = 7'h40;
        cyc("t4_same", gb(0,6));
        credit_in_all = '0;
        cyc("t4_g3", gb(0,6));
        cyc("t4_g4", gb(0,6));
        cyc("t4_empty", '0);
        req_all       = '0;
        credit_in_all = 7'h40;
        for (int n = 0; n < B; n++) cyc("t4_refill", '0);
        check_eq("t4_no_ovf", credit_ovf_err, 1'b0);
        cyc("t4_extra", '0);
        check_eq("t4_ovf_set", credit_ovf_err, 1'b1);
        credit_in_all = '0;
        req_all       = gb(0,6);
        for (int n = 0; n < B; n++) cyc("t4_sat_grant", gb(0,6));
        cyc("t4_sat_empty", '0);
        check_eq("t4_ovf_sticky", credit_ovf_err, 1'b1);
        do_reset();
        check_eq("t4_ovf_clr", credit_ovf_err, 1'b0);

        // Test 5: multi-bit request row is reduced to its lowest output
        req_all  = gb(3,1) | gb(3,4) | gb(4,4);
        tail_all = 7'h7f;
        cyc("t5_sanitise", gb(3,1) | gb(4,4));

        // Test 6: asynchronous reset while output 5 is locked
        do_reset();
        req_all  = gb(0,5);
        tail_all = '0;
        for (int n = 0; n < 3; n++) cyc("t6_flit", gb(0,5));
        req_all = gb(6,5);
        cyc("t6_locked", '0);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_grant", grant_all, '0);
        check_eq("t6_rst_avail", outport_available_all, 7'h7f);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        tail_all = 7'h7f;
        for (int n = 0; n < B; n++) cyc("t6_post", gb(6,5));
        cyc("t6_empty", '0);
        check_eq("t6_avail5", outport_available_all[5], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
